fmac_norm_pipe: RTL and testbench

Two-stage pipelined normalizer for the FMAC datapath. It sits directly downstream of the end-around-carry adders, which produce the 3*C_MANT+5-bit positive sum. The block counts leading zeros, left-shifts the sum so that the hidden bit is in the MSB, and adjusts the exponent, clamping the shift to keep denormals intact. It hands the rounding stage a (C_MANT+1)-bit mantissa plus round and sticky bits, under a valid/ready handshake.

---
 rtl/fmac_norm_pipe.sv | 127 ++++++++++++
 tb/tb_fmac_norm_pipe.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fmac_norm_pipe.sv
// Two-stage FMAC normalizer: leading-zero count, exponent-clamped left shift,
// and extraction of mantissa/round/sticky under a valid/ready handshake.
module fmac_norm_pipe #(
  parameter int C_MANT = 23,
  parameter int C_EXP  = 8,
  localparam int W  = 3*C_MANT+5,
  localparam int LW = $clog2(W+1),
  localparam int EW = C_EXP+2+LW
) (
  input  logic                Clk_CI,
  input  logic                Rst_RI,
  input  logic                Valid_SI,
  output logic                Ready_SO,
  input  logic [W-1:0]        Sum_pos_DI,
  input  logic                Sign_DI,
  input  logic [C_EXP+1:0]    Exp_DI,
  input  logic                Minus_sticky_bit_SI,
  output logic                Valid_SO,
  input  logic                Ready_SI,
  output logic [C_MANT:0]     Mant_norm_DO,
  output logic                Round_bit_SO,
  output logic                Sticky_bit_SO,
  output logic [C_EXP+1:0]    Exp_norm_DO,
  output logic                Sign_SO,
  output logic                Denorm_SO,
  output logic                Zero_SO,
  output logic [LW-1:0]       Lzc_DO
);

  function automatic logic [LW-1:0] count_lz(input logic [W-1:0] v);
    count_lz = LW'(W);
    for (int i = 0; i < W; i++)
      if (v[i]) count_lz = LW'(W-1-i);
  endfunction

  logic v1, v2, adv1, adv2;

  logic [W-1:0]     s1_sum;
  logic             s1_sign, s1_sticky, s1_denorm, s1_zero;
  logic [C_EXP+1:0] s1_exp;
  logic [LW-1:0]    s1_sh, s1_lzc;

  logic [LW-1:0]    lzc_in, sh_in;
  logic [C_EXP+1:0] exp_m1;
  logic             denorm_in, zero_in;

  logic [W-1:0]     shifted;
  logic [C_MANT:0]  mant_nx;
  logic             round_nx, sticky_nx;
  logic [C_EXP+1:0] exp_nx;

  assign adv2     = ~v2 | Ready_SI;
  assign adv1     = ~v1 | adv2;
  assign Ready_SO = adv1;
  assign Valid_SO = v2;

  // The shift stops one short of the exponent so a denormal keeps exponent 1.
  always_comb begin
    lzc_in = count_lz(Sum_pos_DI);
    exp_m1 = '0;
    sh_in  = '0;
    if (!Exp_DI[C_EXP+1] && (Exp_DI != '0)) begin
      exp_m1 = Exp_DI - (C_EXP+2)'(1);
      if (EW'(lzc_in) <= EW'(exp_m1))
        sh_in = lzc_in;
      else
        sh_in = LW'(exp_m1);
    end
    denorm_in = (sh_in < lzc_in) && (Sum_pos_DI != '0);
    zero_in   = (Sum_pos_DI == '0) && !Minus_sticky_bit_SI;
  end

  always_comb begin
    shifted   = s1_sum << s1_sh;
    mant_nx   = shifted[W-1 -: C_MANT+1];
    round_nx  = shifted[W-2-C_MANT];
    sticky_nx = (|shifted[W-3-C_MANT:0]) | s1_sticky;
    exp_nx    = s1_zero ? '0 : (s1_exp - (C_EXP+2)'(s1_sh));
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      s1_sum        <= '0;
      s1_sign       <= 1'b0;
      s1_sticky     <= 1'b0;
      s1_denorm     <= 1'b0;
      s1_zero       <= 1'b0;
      s1_exp        <= '0;
      s1_sh         <= '0;
      s1_lzc        <= '0;
      Mant_norm_DO  <= '0;
      Round_bit_SO  <= 1'b0;
      Sticky_bit_SO <= 1'b0;
      Exp_norm_DO   <= '0;
      Sign_SO       <= 1'b0;
      Denorm_SO     <= 1'b0;
      Zero_SO       <= 1'b0;
      Lzc_DO        <= '0;
    end else begin
      if (adv1) begin
        v1        <= Valid_SI;
        s1_sum    <= Sum_pos_DI;
        s1_sign   <= Sign_DI;
        s1_sticky <= Minus_sticky_bit_SI;
        s1_exp    <= Exp_DI;
        s1_sh     <= sh_in;
        s1_lzc    <= lzc_in;
        s1_denorm <= denorm_in;
        s1_zero   <= zero_in;
      end
      if (adv2) begin
        v2            <= v1;
        Mant_norm_DO  <= mant_nx;
        Round_bit_SO  <= round_nx;
        Sticky_bit_SO <= sticky_nx;
        Exp_norm_DO   <= exp_nx;
        Sign_SO       <= s1_sign;
        Denorm_SO     <= s1_denorm;
        Zero_SO       <= s1_zero;
        Lzc_DO        <= s1_lzc;
      end
    end
  end

endmodule

// File: tb/tb_fmac_norm_pipe.sv
// Directed self-checking bench for fmac_norm_pipe (C_MANT=23, C_EXP=8, W=74).
module tb_fmac_norm_pipe;
  localparam int W = 74;

  logic          Clk_CI = 1'b0;
  logic          Rst_RI;
  logic          Valid_SI;
  logic          Ready_SO;
  logic [W-1:0]  Sum_pos_DI;
  logic          Sign_DI;
  logic [9:0]    Exp_DI;
  logic          Minus_sticky_bit_SI;
  logic          Valid_SO;
  logic          Ready_SI;
  logic [23:0]   Mant_norm_DO;
  logic          Round_bit_SO;
  logic          Sticky_bit_SO;
  logic [9:0]    Exp_norm_DO;
  logic          Sign_SO;
  logic          Denorm_SO;
  logic          Zero_SO;
  logic [6:0]    Lzc_DO;

  int n_asserts = 0;
  int n_fail    = 0;
  int acc, rx;
  logic fire_in, fire_out;
  logic [W-1:0] v;

  always #5 Clk_CI = ~Clk_CI;

  fmac_norm_pipe dut (
    .Clk_CI(Clk_CI), .Rst_RI(Rst_RI), .Valid_SI(Valid_SI), .Ready_SO(Ready_SO),
    .Sum_pos_DI(Sum_pos_DI), .Sign_DI(Sign_DI), .Exp_DI(Exp_DI),
    .Minus_sticky_bit_SI(Minus_sticky_bit_SI), .Valid_SO(Valid_SO), .Ready_SI(Ready_SI),
    .Mant_norm_DO(Mant_norm_DO), .Round_bit_SO(Round_bit_SO), .Sticky_bit_SO(Sticky_bit_SO),
    .Exp_norm_DO(Exp_norm_DO), .Sign_SO(Sign_SO), .Denorm_SO(Denorm_SO),
    .Zero_SO(Zero_SO), .Lzc_DO(Lzc_DO)
  );

  task automatic checkEq(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Drives one beat into an empty pipe and follows it to the output.
  task automatic applyStimulus(input string tag, input logic [W-1:0] sum, input logic sgn,
                               input logic [9:0] exp, input logic stk);
    @(negedge Clk_CI);
    Valid_SI = 1'b1; Ready_SI = 1'b1;
    Sum_pos_DI = sum; Sign_DI = sgn; Exp_DI = exp; Minus_sticky_bit_SI = stk;
    #1 checkEq({tag, "_ready"}, 80'(Ready_SO), 80'd1);
    @(posedge Clk_CI); #1;
    Valid_SI = 1'b0;
    checkEq({tag, "_valid_k1"}, 80'(Valid_SO), 80'd0);
    @(posedge Clk_CI); #1;
    checkEq({tag, "_valid_k2"}, 80'(Valid_SO), 80'd1);
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] mant, input logic r,
                             input logic s, input logic [9:0] exp, input logic sgn,
                             input logic den, input logic zero, input logic [6:0] lzc);
    checkEq({tag, "_mant"},   80'(Mant_norm_DO),  80'(mant));
    checkEq({tag, "_round"},  80'(Round_bit_SO),  80'(r));
    checkEq({tag, "_sticky"}, 80'(Sticky_bit_SO), 80'(s));
    checkEq({tag, "_exp"},    80'(Exp_norm_DO),   80'(exp));
    checkEq({tag, "_sign"},   80'(Sign_SO),       80'(sgn));
    checkEq({tag, "_denorm"}, 80'(Denorm_SO),     80'(den));
    checkEq({tag, "_zero"},   80'(Zero_SO),       80'(zero));
    checkEq({tag, "_lzc"},    80'(Lzc_DO),        80'(lzc));
    @(posedge Clk_CI); #1;
    checkEq({tag, "_drained"}, 80'(Valid_SO), 80'd0);
  endtask

  initial begin
    Rst_RI = 1'b1; Valid_SI = 1'b0; Ready_SI = 1'b1;
    Sum_pos_DI = '0; Sign_DI = 1'b0; Exp_DI = '0; Minus_sticky_bit_SI = 1'b0;
    repeat (2) @(posedge Clk_CI);
    #1;
    checkEq("rst_valid", 80'(Valid_SO), 80'd0);
    checkEq("rst_mant", 80'(Mant_norm_DO), 80'd0);
    checkEq("rst_lzc", 80'(Lzc_DO), 80'd0);
    checkEq("rst_exp", 80'(Exp_norm_DO), 80'd0);
    @(negedge Clk_CI); Rst_RI = 1'b0;
    #1 checkEq("rst_ready", 80'(Ready_SO), 80'd1);

    v = '0; v[73] = 1'b1;
    applyStimulus("norm", v, 1'b0, 10'd127, 1'b0);
    checkOutput("norm", 24'h800000, 1'b0, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 7'd0);

    v = '0; v[50] = 1'b1;
    applyStimulus("shift", v, 1'b1, 10'd100, 1'b0);
    checkOutput("shift", 24'h800000, 1'b0, 1'b0, 10'd77, 1'b1, 1'b0, 1'b0, 7'd23);

    applyStimulus("edge", v, 1'b0, 10'd24, 1'b0);
    checkOutput("edge", 24'h800000, 1'b0, 1'b0, 10'd1, 1'b0, 1'b0, 1'b0, 7'd23);

    applyStimulus("clamp", v, 1'b0, 10'd10, 1'b0);
    checkOutput("clamp", 24'h000200, 1'b0, 1'b0, 10'd1, 1'b0, 1'b1, 1'b0, 7'd23);

    applyStimulus("negexp", v, 1'b0, 10'h3FD, 1'b0);
    checkOutput("negexp", 24'h000001, 1'b0, 1'b0, 10'h3FD, 1'b0, 1'b1, 1'b0, 7'd23);

    v = '0; v[73] = 1'b1; v[49] = 1'b1; v[0] = 1'b1;
    applyStimulus("rs", v, 1'b0, 10'd5, 1'b0);
    checkOutput("rs", 24'h800000, 1'b1, 1'b1, 10'd5, 1'b0, 1'b0, 1'b0, 7'd0);

    v = '0; v[60] = 1'b1;
    applyStimulus("exp1stk", v, 1'b0, 10'd1, 1'b1);
    checkOutput("exp1stk", 24'h000400, 1'b0, 1'b1, 10'd1, 1'b0, 1'b1, 1'b0, 7'd13);

    applyStimulus("zero", '0, 1'b0, 10'd50, 1'b0);
    checkOutput("zero", 24'h000000, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 7'd74);

    applyStimulus("zstk", '0, 1'b1, 10'd1, 1'b1);
    checkOutput("zstk", 24'h000000, 1'b0, 1'b1, 10'd1, 1'b1, 1'b0, 1'b0, 7'd74);

    // Five back-to-back beats tagged by exponent, downstream stalled for cycles 2-5.
    acc = 0; rx = 0;
    v = '0; v[73] = 1'b1;
    for (int c = 0; c < 40 && rx < 5; c++) begin
      @(negedge Clk_CI);
      Ready_SI = !(c >= 2 && c <= 5);
      Valid_SI = (acc < 5);
      Sum_pos_DI = v; Sign_DI = 1'b0; Minus_sticky_bit_SI = 1'b0;
      Exp_DI = 10'(20 + acc);
      #1;
      if (c == 2) checkEq("bp_ready_full", 80'(Ready_SO), 80'd0);
      if (c >= 3 && c <= 5) begin
        checkEq("bp_stall_valid", 80'(Valid_SO), 80'd1);
        checkEq("bp_stall_exp", 80'(Exp_norm_DO), 80'd20);
      end
      fire_in  = Valid_SI & Ready_SO;
      fire_out = Valid_SO & Ready_SI;
      if (fire_out) begin
        checkEq("bp_order", 80'(Exp_norm_DO), 80'(20 + rx));
        rx++;
      end
      @(posedge Clk_CI);
      if (fire_in) acc++;
    end
    #1;
    Valid_SI = 1'b0;
    checkEq("bp_delivered", 80'(rx), 80'd5);
    checkEq("bp_accepted", 80'(acc), 80'd5);
    checkEq("bp_no_dup", 80'(Valid_SO), 80'd0);

    // Two beats parked in the pipe, then reset.
    @(negedge Clk_CI);
    Ready_SI = 1'b0; Valid_SI = 1'b1; Exp_DI = 10'd40;
    @(negedge Clk_CI);
    Exp_DI = 10'd41;
    @(negedge Clk_CI);
    Valid_SI = 1'b0;
    checkEq("rst_inflight_valid", 80'(Valid_SO), 80'd1);
    Rst_RI = 1'b1;
    @(posedge Clk_CI); #1;
    checkEq("rst_mid_valid", 80'(Valid_SO), 80'd0);
    checkEq("rst_mid_exp", 80'(Exp_norm_DO), 80'd0);
    @(negedge Clk_CI);
    Rst_RI = 1'b0; Ready_SI = 1'b1;
    #1 checkEq("rst_mid_ready", 80'(Ready_SO), 80'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk_CI); #1;
      checkEq("rst_no_stale", 80'(Valid_SO), 80'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
